// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-memory loader: state encoding,
// default sizes and stream framing constants.
package mips_pkg;

  localparam int MAX_WORDS_DEF  = 256;
  localparam int CNT_W_DEF      = 16;
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_LEN_W      = 8 * HDR_BYTES;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_WORD,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_e;

endpackage

// File: rtl/mips_word_assembler.sv
// Big-endian byte-to-word assembler: the first byte loaded after a clear
// ends up in the most significant byte of the word.
module mips_word_assembler
  import mips_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_clr,
  input  logic                          i_load,
  input  logic [7:0]                    i_byte,
  output logic [8*BYTES_PER_WORD-1:0]   o_word,
  output logic                          o_full
);

  logic [8*BYTES_PER_WORD-1:0] r_shift;
  logic [IDX_W-1:0]            r_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      // NOTE: the shift register is reset too, so W_Ins is never X after reset.
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_shift <= {r_shift[8*BYTES_PER_WORD-9:0], i_byte};
      r_idx   <= r_idx + IDX_W'(1);
    end
  end

  assign o_word = r_shift;
  // High while the next loaded byte completes the word; the index then wraps to 0.
  assign o_full = (r_idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mips_imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into the IMem
// write port and holds the core in reset until a good image has landed.
module mips_imem_loader
  import mips_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [31:0]      W_Ins,
  output logic             WE,
  output logic [CNT_W-1:0] W_Addr,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] word_count
);

  loader_state_e          r_state;
  loader_state_e          w_state;
  logic [7:0]             r_csum;
  logic [7:0]             r_len_hi;
  logic [CNT_W-1:0]       r_length;
  logic [CNT_W-1:0]       r_word_count;
  logic [CNT_W-1:0]       w_count_inc;
  logic [31:0]            r_w_ins;
  logic [31:0]            w_asm_word;
  logic                   w_asm_full;
  logic                   w_asm_clr;
  logic                   w_asm_load;
  logic                   w_accept;
  logic                   w_start_ok;
  logic                   w_len_bad;
  logic [HDR_LEN_W-1:0]   w_hdr_len;

  assign w_start_ok  = start && (r_state inside {S_IDLE, S_DONE, S_ERR});
  assign byte_ready  = r_state inside {S_HDR_HI, S_HDR_LO, S_WORD, S_CSUM};
  assign w_accept    = byte_valid && byte_ready;
  assign w_hdr_len   = {r_len_hi, byte_in};
  assign w_len_bad   = (w_hdr_len == '0) || (int'(w_hdr_len) > MAX_WORDS);
  assign w_count_inc = r_word_count + CNT_W'(1);
  assign w_asm_clr   = w_start_ok || ((r_state == S_HDR_LO) && w_accept);
  assign w_asm_load  = (r_state == S_WORD) && w_accept;

  mips_word_assembler u_asm (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_clr  (w_asm_clr),
    .i_load (w_asm_load),
    .i_byte (byte_in),
    .o_word (w_asm_word),
    .o_full (w_asm_full)
  );

  always_comb begin
    // NOTE: default first so every path assigns w_state and no latch is inferred.
    w_state = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_state = S_HDR_HI;
      S_HDR_HI:              if (w_accept) w_state = S_HDR_LO;
      S_HDR_LO:              if (w_accept) w_state = w_len_bad ? S_ERR : S_WORD;
      S_WORD:                if (w_accept && w_asm_full) w_state = S_WRITE;
      S_WRITE:               w_state = (w_count_inc == r_length) ? S_CSUM : S_WORD;
      S_CSUM:                if (w_accept) w_state = (byte_in == r_csum) ? S_DONE : S_ERR;
      default:               w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_csum       <= '0;
      r_len_hi     <= '0;
      r_length     <= '0;
      r_word_count <= '0;
      r_w_ins      <= '0;
    end else begin
      r_state <= w_state;
      if (w_start_ok) begin
        r_csum       <= '0;
        r_word_count <= '0;
      end
      // The checksum byte itself is compared, never folded in.
      if (w_accept && (r_state != S_CSUM)) r_csum <= r_csum ^ byte_in;
      if (w_accept && (r_state == S_HDR_HI)) r_len_hi <= byte_in;
      if (w_accept && (r_state == S_HDR_LO) && !w_len_bad) r_length <= CNT_W'(w_hdr_len);
      if (r_state == S_WRITE) begin
        r_word_count <= w_count_inc;
        r_w_ins      <= w_asm_word;
      end
    end
  end

  // W_Ins shows the fresh word during the strobe and holds it afterwards,
  // while the assembler is already shifting in the next word.
  assign WE         = (r_state == S_WRITE);
  assign W_Ins      = WE ? w_asm_word : r_w_ins;
  assign W_Addr     = r_word_count;
  assign word_count = r_word_count;
  assign busy       = byte_ready || WE;
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_ERR);
  assign core_rst   = !done || w_start_ok;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Randomized scoreboard bench for mips_imem_loader: a stream-level model
// predicts IMem writes and final status; a monitor checks every cycle.
module tb_mips_imem_loader;

  localparam int MAX_W = 256;
  localparam int CW    = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [31:0]   W_Ins;
  logic          WE;
  logic [CW-1:0] W_Addr;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] word_count;

  mips_imem_loader dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .W_Ins      (W_Ins),
    .WE         (WE),
    .W_Addr     (W_Addr),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 CLK = ~CLK;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected writes on every WE and checks per-cycle handshake rules.
  initial begin
    wr_t         w;
    logic        rst_at_edge;
    logic [31:0] hold_exp;
    hold_exp = 32'h0;
    forever begin
      @(posedge CLK);
      rst_at_edge = RST;
      #1;
      if (rst_at_edge) begin
        hold_exp = 32'h0;
        check("we_low_after_rst", 64'(WE), 64'(0));
      end else if (WE) begin
        check("we_expected", 64'(exp_q.size() != 0), 64'(1));
        check("byte_ready_low_in_write", 64'(byte_ready), 64'(0));
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("we_addr", 64'(W_Addr), 64'(w.addr));
          check("we_data", 64'(W_Ins), 64'(w.data));
          check("we_word_count", 64'(word_count), 64'(w.addr));
          hold_exp = w.data;
        end
      end else begin
        check("w_ins_hold", 64'(W_Ins), 64'(hold_exp));
        if (busy) check("byte_ready_when_busy", 64'(byte_ready), 64'(1));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic bq_t make_image(input wq_t words, input logic [7:0] mask);
    bq_t        q;
    logic [7:0] x;
    int         n;
    n = words.size();
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    foreach (words[i]) begin
      q.push_back(words[i][31:24]);
      q.push_back(words[i][23:16]);
      q.push_back(words[i][15:8]);
      q.push_back(words[i][7:0]);
    end
    x = 8'h00;
    foreach (q[i]) x ^= q[i];
    q.push_back(x ^ mask);
    return q;
  endfunction

  // Present one byte after an optional idle gap and wait for the handshake.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
    repeat (gap) begin
      @(posedge CLK);
      #1;
    end
    byte_valid = 1'b1;
    byte_in    = b;
    acc        = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge CLK);
      acc = byte_ready;
      @(posedge CLK);
      #1;
    end
    byte_valid = 1'b0;
    check("byte_accepted", 64'(acc), 64'(1));
  endtask

  task automatic do_start();
    start = 1'b1;
    #1;
    check("core_rst_in_start_cycle", 64'(core_rst), 64'(1));
    @(posedge CLK);
    #1;
    start = 1'b0;
    check("start_busy", 64'(busy), 64'(1));
    check("start_done", 64'(done), 64'(0));
    check("start_err", 64'(err), 64'(0));
    check("start_word_count", 64'(word_count), 64'(0));
    check("start_w_addr", 64'(W_Addr), 64'(0));
    check("start_core_rst", 64'(core_rst), 64'(1));
  endtask

  task automatic check_reset_outputs();
    check("rst_byte_ready", 64'(byte_ready), 64'(0));
    check("rst_w_ins", 64'(W_Ins), 64'(0));
    check("rst_we", 64'(WE), 64'(0));
    check("rst_w_addr", 64'(W_Addr), 64'(0));
    check("rst_core_rst", 64'(core_rst), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_word_count", 64'(word_count), 64'(0));
  endtask

  // Stream-level reference: decide the outcome from the image bytes alone,
  // queue the writes it implies, drive the bytes, then check final status.
  task automatic load_image(input bq_t img, input int gap_mode);
    int         n;
    int         nsend;
    int         exp_wc;
    logic       exp_done;
    logic [7:0] x;
    wr_t        w;
    n = int'({img[0], img[1]});
    if (n == 0 || n > MAX_W) begin
      nsend    = 2;
      exp_done = 1'b0;
      exp_wc   = 0;
    end else begin
      for (int i = 0; i < n; i++) begin
        w.addr = i;
        w.data = {img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]};
        exp_q.push_back(w);
      end
      x = 8'h00;
      for (int i = 0; i < 4*n + 2; i++) x ^= img[i];
      exp_done = (img[4*n+2] == x);
      nsend    = 4*n + 3;
      exp_wc   = n;
    end
    for (int i = 0; i < nsend; i++)
      send_byte(img[i], (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode);
    check("end_done", 64'(done), 64'(exp_done));
    check("end_err", 64'(err), 64'(!exp_done));
    check("end_core_rst", 64'(core_rst), 64'(!exp_done));
    check("end_busy", 64'(busy), 64'(0));
    check("end_byte_ready", 64'(byte_ready), 64'(0));
    check("end_word_count", 64'(word_count), 64'(exp_wc));
    check("end_w_addr", 64'(W_Addr), 64'(exp_wc));
    check("end_sb_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    bq_t        nominal;
    bq_t        img;
    wq_t        words;
    logic [7:0] mask;

    words   = {32'h20080005, 32'h01095020};
    nominal = make_image(words, 8'h00);

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs();
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check_reset_outputs();

    // Nominal load, then bytes offered in DONE must be refused.
    do_start();
    load_image(nominal, 0);
    byte_valid = 1'b1;
    byte_in    = 8'hAA;
    repeat (2) begin
      @(posedge CLK);
      #1;
      check("done_refuses_bytes", 64'(byte_ready), 64'(0));
      check("done_stays", 64'(done), 64'(1));
    end
    byte_valid = 1'b0;

    // Stalled source: one valid cycle then two idle cycles per byte.
    do_start();
    load_image(nominal, 2);

    // Bad lengths: zero and one above the maximum.
    do_start();
    img = {8'h00, 8'h00};
    load_image(img, 0);
    do_start();
    img = {8'h01, 8'h01};
    load_image(img, 0);

    // Bad checksum, then recovery with the correct image.
    img = nominal;
    img[img.size()-1] = 8'h55;
    do_start();
    load_image(img, 0);
    do_start();
    load_image(nominal, 0);

    // Reset with three payload bytes of word 0 taken and the fourth on the bus.
    do_start();
    for (int i = 0; i < 5; i++) send_byte(nominal[i], 0);
    byte_valid = 1'b1;
    byte_in    = nominal[5];
    RST        = 1'b1;
    @(posedge CLK);
    #1;
    RST        = 1'b0;
    byte_valid = 1'b0;
    check_reset_outputs();
    do_start();
    load_image(nominal, -1);

    // Reload a single zero word from DONE.
    words = {32'h00000000};
    img   = make_image(words, 8'h00);
    do_start();
    load_image(img, 0);

    // Longest legal program.
    words = {};
    for (int i = 0; i < MAX_W; i++) words.push_back($urandom);
    img = make_image(words, 8'h00);
    do_start();
    load_image(img, 0);

    // Random images, some with corrupted checksums.
    for (int t = 0; t < 8; t++) begin
      words = {};
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) words.push_back($urandom);
      mask = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      img  = make_image(words, mask);
      do_start();
      load_image(img, -1);
    end

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
